// File: rtl/lcd_ctrl.sv
// 8x8 image buffer controller: loads from ROM after reset, runs point/block commands, writes out.
// Optional define LCD_CTRL_AVG_ROUND_EN makes Average round half up instead of truncating.
module lcd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IROM_Q,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       IROM_EN,
  output logic [5:0] IROM_A,
  output logic       IRB_RW,
  output logic [5:0] IRB_A,
  output logic [7:0] IRB_D,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] StLoad  = 3'd0;
  localparam logic [2:0] StFlush = 3'd1;
  localparam logic [2:0] StIdle  = 3'd2;
  localparam logic [2:0] StExec  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;

  logic [2:0] state_q;
  logic [2:0] cmd_q;
  logic [2:0] x_q, y_q;
  logic       ld_v_q;
  logic [5:0] ld_a_q;
  logic [7:0] img_q [64];

  logic [5:0] ia, ib, ic, id;
  logic [9:0] sum;
  logic [9:0] sum_r;
  logic [7:0] avg;

  always_comb begin
    ia    = {y_q - 3'd1, x_q - 3'd1};
    ib    = ia + 6'd1;
    ic    = ia + 6'd8;
    id    = ia + 6'd9;
    sum   = {2'b00, img_q[ia]} + {2'b00, img_q[ib]} + {2'b00, img_q[ic]} + {2'b00, img_q[id]};
`ifdef LCD_CTRL_AVG_ROUND_EN
    sum_r = sum + 10'd2;
`else
    sum_r = sum;
`endif
    avg   = sum_r[9:2];
  end

  // Control, point and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
      cmd_q   <= 3'd0;
      x_q     <= 3'd4;
      y_q     <= 3'd4;
      ld_v_q  <= 1'b0;
      ld_a_q  <= 6'd0;
      IROM_EN <= 1'b1;
      IROM_A  <= 6'd0;
      IRB_RW  <= 1'b1;
      IRB_A   <= 6'd0;
      IRB_D   <= 8'd0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done   <= 1'b0;
      ld_v_q <= 1'b0;
      case (state_q)
        StLoad: begin
          // ROM data for the address presented this cycle arrives next cycle.
          ld_v_q <= ~IROM_EN;
          ld_a_q <= IROM_A;
          if (IROM_EN) begin
            IROM_EN <= 1'b0;
          end else if (IROM_A == 6'd63) begin
            IROM_EN <= 1'b1;
            IROM_A  <= 6'd0;
            state_q <= StFlush;
          end else begin
            IROM_A <= IROM_A + 6'd1;
          end
        end
        StFlush: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        StIdle: begin
          if (cmd_valid) begin
            busy  <= 1'b1;
            cmd_q <= cmd;
            if (cmd == 3'd0) begin
              state_q <= StWrite;
              IRB_RW  <= 1'b0;
              IRB_A   <= 6'd0;
              IRB_D   <= img_q[0];
            end else begin
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          busy    <= 1'b0;
          state_q <= StIdle;
          case (cmd_q)
            3'd1: if (y_q > 3'd1) y_q <= y_q - 3'd1;
            3'd2: if (y_q < 3'd7) y_q <= y_q + 3'd1;
            3'd3: if (x_q > 3'd1) x_q <= x_q - 3'd1;
            3'd4: if (x_q < 3'd7) x_q <= x_q + 3'd1;
            default: ;
          endcase
        end
        StWrite: begin
          if (IRB_A == 6'd63) begin
            IRB_RW  <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            IRB_A <= IRB_A + 6'd1;
            IRB_D <= img_q[IRB_A + 6'd1];
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  // Image buffer: no reset, contents are always reloaded after reset.
  always_ff @(posedge clk) begin
    if (ld_v_q) begin
      img_q[ld_a_q] <= IROM_Q;
    end
    if (state_q == StExec) begin
      case (cmd_q)
        3'd5: begin
          img_q[ia] <= avg;
          img_q[ib] <= avg;
          img_q[ic] <= avg;
          img_q[id] <= avg;
        end
        3'd6: begin
          img_q[ia] <= img_q[ic];
          img_q[ic] <= img_q[ia];
          img_q[ib] <= img_q[id];
          img_q[id] <= img_q[ib];
        end
        3'd7: begin
          img_q[ia] <= img_q[ib];
          img_q[ib] <= img_q[ia];
          img_q[ic] <= img_q[id];
          img_q[id] <= img_q[ic];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: a pixel-grid reference model queues expected IRB writes,
// a negedge monitor pops and compares them.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] IROM_Q = 8'd0;
  logic [2:0] cmd = 3'd0;
  logic       cmd_valid = 1'b0;
  logic       IROM_EN;
  logic [5:0] IROM_A;
  logic       IRB_RW;
  logic [5:0] IRB_A;
  logic [7:0] IRB_D;
  logic       busy;
  logic       done;

`ifdef LCD_CTRL_AVG_ROUND_EN
  localparam int ExpAvg = 32;
`else
  localparam int ExpAvg = 31;
`endif

  lcd_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .IROM_Q   (IROM_Q),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .IROM_EN  (IROM_EN),
    .IROM_A   (IROM_A),
    .IRB_RW   (IRB_RW),
    .IRB_A    (IRB_A),
    .IRB_D    (IRB_D),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [64];
  always @(posedge clk) if (!IROM_EN) IROM_Q <= rom[IROM_A];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel grid indexed [row][col] and operation point (mx, my).
  typedef struct {int a; int d;} wr_t;
  wr_t exp_q[$];
  int  pix[8][8];
  int  mx, my;
  int  irb_seen[64];

  task automatic model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) pix[r][c] = rom[r*8+c];
    mx = 4;
    my = 4;
  endtask

  task automatic model_apply(input int cm);
    int s, t;
    case (cm)
      0: for (int r = 0; r < 8; r++)
           for (int c = 0; c < 8; c++) exp_q.push_back('{r*8+c, pix[r][c]});
      1: if (my > 1) my--;
      2: if (my < 7) my++;
      3: if (mx > 1) mx--;
      4: if (mx < 7) mx++;
      5: begin
        s = pix[my-1][mx-1] + pix[my-1][mx] + pix[my][mx-1] + pix[my][mx];
`ifdef LCD_CTRL_AVG_ROUND_EN
        s = (s + 2) / 4;
`else
        s = s / 4;
`endif
        pix[my-1][mx-1] = s; pix[my-1][mx] = s; pix[my][mx-1] = s; pix[my][mx] = s;
      end
      6: begin
        t = pix[my-1][mx-1]; pix[my-1][mx-1] = pix[my][mx-1]; pix[my][mx-1] = t;
        t = pix[my-1][mx];   pix[my-1][mx]   = pix[my][mx];   pix[my][mx]   = t;
      end
      default: begin
        t = pix[my-1][mx-1]; pix[my-1][mx-1] = pix[my-1][mx]; pix[my-1][mx] = t;
        t = pix[my][mx-1];   pix[my][mx-1]   = pix[my][mx];   pix[my][mx]   = t;
      end
    endcase
  endtask

  wr_t mon_e;
  always @(negedge clk) begin
    if (reset && IRB_RW === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0d, expected no write", IRB_A, IRB_D);
      end else begin
        mon_e = exp_q.pop_front();
        check("irb_addr", 32'(IRB_A), mon_e.a);
        check("irb_data", 32'(IRB_D), mon_e.d);
        irb_seen[IRB_A] = int'(IRB_D);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 32'(busy), 0);
  endtask

  task automatic do_reset(input bit full);
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("rst_irom_en", 32'(IROM_EN), 1);
    check("rst_irom_a", 32'(IROM_A), 0);
    check("rst_irb_rw", 32'(IRB_RW), 1);
    check("rst_irb_a", 32'(IRB_A), 0);
    check("rst_irb_d", 32'(IRB_D), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_done", 32'(done), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("load_first_en", 32'(IROM_EN), 0);
    check("load_first_a", 32'(IROM_A), 0);
    @(negedge clk);
    check("load_second_a", 32'(IROM_A), 1);
    if (full) wait_idle();
  endtask

  task automatic issue(input int c);
    int k;
    @(negedge clk);
    wait_idle();
    cmd_valid = 1'b1;
    cmd = 3'(c);
    @(posedge clk);
    model_apply(c);
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 1);
    cmd_valid = 1'($urandom);
    cmd = 3'($urandom);
    if (c != 0) begin
      @(negedge clk);
      check("busy_one_cycle", 32'(busy), 0);
      cmd_valid = 1'b0;
    end else begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (done !== 1'b1) begin
          cmd_valid = 1'($urandom);
          cmd = 3'($urandom);
        end
      end while (done !== 1'b1 && k < 80);
      cmd_valid = 1'b0;
      check("done_pulse", 32'(done), 1);
      check("busy_after_write", 32'(busy), 0);
      check("rw_idle", 32'(IRB_RW), 1);
      check("write_count", 32'(exp_q.size()), 0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 0);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    for (int i = 0; i < 64; i++) rom[i] = 8'(i);

    // Plain load and write-out.
    do_reset(1'b1);
    issue(0);
    check("irb_0", irb_seen[0], 0);
    check("irb_63", irb_seen[63], 63);

    // Average at the reset point.
    do_reset(1'b1);
    issue(5);
    issue(0);
    check("avg_27", irb_seen[27], ExpAvg);
    check("avg_28", irb_seen[28], ExpAvg);
    check("avg_35", irb_seen[35], ExpAvg);
    check("avg_36", irb_seen[36], ExpAvg);
    check("avg_26", irb_seen[26], 26);

    // Clamp at top-left, mirror rows.
    do_reset(1'b1);
    repeat (5) issue(1);
    repeat (5) issue(3);
    issue(6);
    issue(0);
    check("mx_0", irb_seen[0], 8);
    check("mx_1", irb_seen[1], 9);
    check("mx_8", irb_seen[8], 0);
    check("mx_9", irb_seen[9], 1);

    // Clamp at bottom-right, mirror columns.
    do_reset(1'b1);
    repeat (5) issue(2);
    repeat (5) issue(4);
    issue(7);
    issue(0);
    check("my_54", irb_seen[54], 55);
    check("my_55", irb_seen[55], 54);
    check("my_62", irb_seen[62], 63);
    check("my_63", irb_seen[63], 62);

    // Random image, reset aborted mid-load, then random command stream.
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    do_reset(1'b0);
    k = 0;
    while (IROM_A !== 6'd30 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reached_addr_30", 32'(IROM_A), 30);
    do_reset(1'b1);
    issue(0);
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 7)));
    end
    issue(0);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 The module SHALL have ports: clk  in  1  single system clock, all state on rising edge.
REQ-002 The module SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 The module SHALL have ports: IROM_Q  in  8  image ROM read data, registered by ROM one clk after address.
REQ-004 The module SHALL have ports: cmd  in  3  command code; cmd_valid  in  1  command strobe.
REQ-005 The module SHALL have ports: IROM_EN  out  1  ROM chip enable, active-low; IROM_A  out  6  ROM address.
REQ-006 The module SHALL have ports: IRB_RW  out  1  buffer write enable, 0=write, 1=idle/read; IRB_A  out  6  buffer address; IRB_D  out  8  buffer write data.
REQ-007 The module SHALL have ports: busy  out  1  1=commands not accepted; done  out  1  one-cycle write-complete pulse.

Function
REQ-008 Image SHALL be 8x8 pixels, 8 bits each, held in an internal 64x8 buffer; address = row*8 + col.
REQ-009 After reset the block SHALL load the image: IROM_EN=0, IROM_A stepping 0..63 one per clk, storing IROM_Q for address k one clk after k was presented; then IROM_EN=1, busy=0.
REQ-010 Operation point (X,Y) SHALL reset to (4,4); operated block = pixels (Y-1,X-1),(Y-1,X),(Y,X-1),(Y,X) as (row,col).
REQ-011 A command SHALL be accepted at a rising edge where cmd_valid=1 and busy=0; busy SHALL be 1 from that edge until processing completes.
REQ-012 cmd=0 Write: SHALL write buffer to IRB, IRB_RW=0, IRB_A=k, IRB_D=buf[k], k=0..63 one per clk; then IRB_RW=1, done=1 for exactly one clk, busy=0.
REQ-013 cmd=1 Up: Y=Y-1 if Y>1 else unchanged; cmd=2 Down: Y=Y+1 if Y<7; cmd=3 Left: X=X-1 if X>1; cmd=4 Right: X=X+1 if X<7.
REQ-014 cmd=5 Average: all four block pixels SHALL become floor(sum/4), sum computed in 10 bits.
REQ-015 cmd=6 Mirror X: SHALL swap row Y-1 with row Y within the block (both columns).
REQ-016 cmd=7 Mirror Y: SHALL swap column X-1 with column X within the block (both rows).
REQ-017 Commands 1-7 SHALL complete in one clk after acceptance: busy=1 for exactly one cycle, then 0.
REQ-018 cmd_valid while busy=1 SHALL be ignored; cmd SHALL be sampled only at acceptance.
REQ-019 After done, further commands SHALL be accepted normally; buffer and (X,Y) retained.
REQ-020 IRB_A/IRB_D SHALL hold last values when not writing; IROM_A SHALL hold 0 after load.

Reset
REQ-021 While reset=0: IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, busy=1, done=0, (X,Y)=(4,4), state=LOAD start.
REQ-022 Reset asserted mid-load, mid-write or mid-command SHALL abort immediately; after release the full image load SHALL restart from address 0.
REQ-023 First ROM access SHALL occur on the first rising clk edge after reset release.

Configuration
REQ-024 Macro LCD_CTRL_AVG_ROUND_EN: if defined, Average SHALL produce (sum+2)>>2 (round half up); if undefined, floor(sum/4) per REQ-014.

Verification
REQ-025 ROM[k]=k; reset; cmd 0 -> IRB[k]=k for all k, done pulses one clk, IRB_RW returns 1.
REQ-026 ROM[k]=k; cmd 5, cmd 0 -> IRB[27],[28],[35],[36]=31 (sum 126), all others unchanged; with macro -> 32.
REQ-027 ROM[k]=k; cmd 1 x5, cmd 3 x5, cmd 6, cmd 0 -> point clamps at (1,1); IRB[0]=8,[1]=9,[8]=0,[9]=1.
REQ-028 ROM[k]=k; cmd 2 x5, cmd 4 x5, cmd 7, cmd 0 -> point clamps at (7,7); IRB[54]=55,[55]=54,[62]=63,[63]=62.
REQ-029 cmd_valid held 1 with changing cmd during busy -> only cmd sampled at busy=0 edges take effect; busy=1 exactly one clk per non-write command.
REQ-030 reset=0 asserted at load address 30 -> outputs at reset values immediately; after release load restarts at IROM_A=0 and final Write matches ROM.
